// File: rtl/row_dec_pkg.sv
// Shared constants and decode helpers for the row-address decode path.
package row_dec_pkg;
  localparam int ROW_WORD_W     = 12;
  localparam int ROW_ADDR_W     = 8;
  localparam int SYND_MAX_VALID = 12;
  // Word index carrying Gray bit g0..g7.
  localparam int GRAY_MAP [ROW_ADDR_W] = '{2, 4, 5, 11, 8, 9, 10, 6};

  // Syndrome = XOR of the 1-based positions of all set bits.
  function automatic logic [3:0] hamming_syndrome(input logic [ROW_WORD_W-1:0] w);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < ROW_WORD_W; i++)
      if (w[i]) s = s ^ 4'(i + 1);
    return s;
  endfunction

  // MSB passes through; each lower bit folds in the binary bit above it.
  function automatic logic [ROW_ADDR_W-1:0] gray_to_bin(input logic [ROW_ADDR_W-1:0] g);
    logic [ROW_ADDR_W-1:0] b;
    b = '0;
    b[ROW_ADDR_W-1] = g[ROW_ADDR_W-1];
    for (int k = ROW_ADDR_W - 2; k >= 0; k--) b[k] = b[k+1] ^ g[k];
    return b;
  endfunction
endpackage

// File: rtl/row_dec_arbiter_rr.sv
// Round-robin arbiter: one-hot grant searching upward from the pointer.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int SRC_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [SRC_W-1:0] gnt_idx_o,
  output logic             gnt_vld_o
);
  logic [SRC_W-1:0] ptr_q, ptr_d;

  // First requester at or after the pointer, wrapping; pointer moves past the winner.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (en_i && !gnt_vld_o && req_i[(int'(ptr_q) + k) % N_REQ]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = SRC_W'((int'(ptr_q) + k) % N_REQ);
      end
    end
    if (gnt_vld_o) gnt_o[gnt_idx_o] = 1'b1;
    ptr_d = gnt_vld_o ? SRC_W'((int'(gnt_idx_o) + 1) % N_REQ) : ptr_q;
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
endmodule

// File: rtl/row_dec_arbiter.sv
// Shared Hamming/Gray row decoder: round-robin capture, then decode/output stage.
module row_dec_arbiter
  import row_dec_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int SRC_W = 2,
  parameter int CNT_W = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [ROW_WORD_W*N_REQ-1:0] req_word,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ROW_ADDR_W-1:0]       out_row,
  output logic [SRC_W-1:0]            out_src,
  output logic                        out_corr,
  output logic                        out_uncorr,
  input  logic                        cnt_clr,
  output logic [CNT_W-1:0]            corr_cnt,
  output logic [CNT_W-1:0]            uncorr_cnt
);
  logic                  s1_valid_q;
  logic [ROW_WORD_W-1:0] s1_word_q;
  logic [SRC_W-1:0]      s1_src_q;
  logic                  out_valid_q, out_corr_q, out_uncorr_q;
  logic [ROW_ADDR_W-1:0] out_row_q;
  logic [SRC_W-1:0]      out_src_q;
  logic [CNT_W-1:0]      corr_cnt_q, uncorr_cnt_q;

  logic                  s1_free, s2_free, gnt_vld;
  logic [N_REQ-1:0]      gnt;
  logic [SRC_W-1:0]      gnt_idx;
  logic [3:0]            syn;
  logic [ROW_WORD_W-1:0] fixed;
  logic [ROW_ADDR_W-1:0] gray;
  logic                  dec_corr, dec_uncorr;

  assign s2_free = !out_valid_q || out_ready;
  assign s1_free = !s1_valid_q || s2_free;

  // Grants are suppressed while reset is held so req_ready reads 0 in reset.
  rr_arbiter #(.N_REQ(N_REQ), .SRC_W(SRC_W)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (s1_free && rst_n),
    .req_i     (req_valid),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );
  assign req_ready = gnt;

  // Stage 1: capture the granted word; drains to empty when advancing without a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_word_q  <= '0;
      s1_src_q   <= '0;
    end else if (s1_free) begin
      s1_valid_q <= gnt_vld;
      if (gnt_vld) begin
        s1_word_q <= req_word[ROW_WORD_W*gnt_idx +: ROW_WORD_W];
        s1_src_q  <= gnt_idx;
      end
    end
  end

  // Single-error correction (parity positions only raise the flag), then Gray bit pick.
  always_comb begin
    syn        = hamming_syndrome(s1_word_q);
    fixed      = s1_word_q;
    dec_corr   = (syn != 4'd0) && (int'(syn) <= SYND_MAX_VALID);
    dec_uncorr = int'(syn) > SYND_MAX_VALID;
    if (dec_corr) fixed[int'(syn) - 1] = ~fixed[int'(syn) - 1];
    gray = '0;
    for (int k = 0; k < ROW_ADDR_W; k++) gray[k] = fixed[GRAY_MAP[k]];
  end

  // Stage 2: output registers, held while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_row_q    <= '0;
      out_src_q    <= '0;
      out_corr_q   <= 1'b0;
      out_uncorr_q <= 1'b0;
    end else if (s2_free) begin
      out_valid_q  <= s1_valid_q;
      out_row_q    <= gray_to_bin(gray);
      out_src_q    <= s1_src_q;
      out_corr_q   <= dec_corr;
      out_uncorr_q <= dec_uncorr;
    end
  end

  // Saturating error counters on delivered results; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else if (cnt_clr) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else if (out_valid_q && out_ready) begin
      if (out_corr_q && corr_cnt_q != '1)     corr_cnt_q   <= corr_cnt_q + CNT_W'(1);
      if (out_uncorr_q && uncorr_cnt_q != '1) uncorr_cnt_q <= uncorr_cnt_q + CNT_W'(1);
    end
  end

  assign out_valid  = out_valid_q;
  assign out_row    = out_row_q;
  assign out_src    = out_src_q;
  assign out_corr   = out_corr_q;
  assign out_uncorr = out_uncorr_q;
  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;
endmodule

// File: tb/tb_row_dec_arbiter.sv
// Directed bench for row_dec_arbiter with hand-computed expectations.
module tb_row_dec_arbiter;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [12*N-1:0] req_word;
  logic [N-1:0]  req_ready;
  logic          out_valid, out_ready;
  logic [7:0]    out_row;
  logic [1:0]    out_src;
  logic          out_corr, out_uncorr, cnt_clr;
  logic [7:0]    corr_cnt, uncorr_cnt;

  int nvec  = 0;
  int nfail = 0;

  row_dec_arbiter #(.N_REQ(N), .SRC_W(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_word(req_word),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_src(out_src), .out_corr(out_corr),
    .out_uncorr(out_uncorr), .cnt_clr(cnt_clr), .corr_cnt(corr_cnt),
    .uncorr_cnt(uncorr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated word from requester idx, checked through output and counters.
  task automatic send(input int idx, input logic [11:0] w, input logic [7:0] row,
                      input logic corr, input logic uncorr,
                      input logic [7:0] ccnt, input logic [7:0] ucnt);
    logic [N-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    req_word[12*idx +: 12] = w;
    req_valid = oh;
    #1;
    chk("send_ready", 32'(req_ready), 32'(oh));
    tick();
    req_valid = '0;
    chk("send_lat1_valid", 32'(out_valid), 32'(0));
    tick();
    chk("send_valid", 32'(out_valid), 32'(1));
    chk("send_row", 32'(out_row), 32'(row));
    chk("send_src", 32'(out_src), 32'(idx));
    chk("send_corr", 32'(out_corr), 32'(corr));
    chk("send_uncorr", 32'(out_uncorr), 32'(uncorr));
    tick();
    chk("send_drained", 32'(out_valid), 32'(0));
    chk("send_corr_cnt", 32'(corr_cnt), 32'(ccnt));
    chk("send_uncorr_cnt", 32'(uncorr_cnt), 32'(ucnt));
  endtask

  initial begin
    logic [N-1:0] oh;
    rst_n = 1'b0; req_valid = '0; req_word = '0; out_ready = 1'b1; cnt_clr = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_row", 32'(out_row), 32'(0));
    chk("rst_out_src", 32'(out_src), 32'(0));
    chk("rst_flags", 32'({out_corr, out_uncorr}), 32'(0));
    chk("rst_cnts", 32'({corr_cnt, uncorr_cnt}), 32'(0));
    chk("rst_ready", 32'(req_ready), 32'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    tick();

    // Clean, single-error, double-error, last data position, parity position.
    send(0, 12'h034, 8'h05, 1'b0, 1'b0, 8'd0, 8'd0);
    send(2, 12'h024, 8'h05, 1'b1, 1'b0, 8'd1, 8'd0);
    send(1, 12'h224, 8'h39, 1'b0, 1'b1, 8'd1, 8'd1);
    send(0, 12'h834, 8'h05, 1'b1, 1'b0, 8'd2, 8'd1);
    send(3, 12'h035, 8'h05, 1'b1, 1'b0, 8'd3, 8'd1);

    // All requesters active: strict rotation 0,1,2,3 from pointer 0.
    for (int i = 0; i < N; i++) req_word[12*i +: 12] = 12'h034;
    req_valid = '1;
    #1;
    for (int c = 0; c < 8; c++) begin
      oh = '0;
      oh[c % N] = 1'b1;
      chk("rr_ready", 32'(req_ready), 32'(oh));
      if (c >= 2) begin
        chk("rr_valid", 32'(out_valid), 32'(1));
        chk("rr_src", 32'(out_src), 32'((c - 2) % N));
      end
      tick();
    end
    req_valid = '0;
    repeat (3) tick();
    chk("rr_drained", 32'(out_valid), 32'(0));
    chk("rr_cnts", 32'({corr_cnt, uncorr_cnt}), 32'({8'd3, 8'd1}));

    // Backpressure: two words stored, outputs held, then in-order release.
    req_valid = '1;
    out_ready = 1'b0;
    #1;
    chk("bp_ready0", 32'(req_ready), 32'(4'b0001));
    tick();
    chk("bp_ready1", 32'(req_ready), 32'(4'b0010));
    chk("bp_not_yet", 32'(out_valid), 32'(0));
    tick();
    for (int h = 0; h < 5; h++) begin
      chk("bp_hold_valid", 32'(out_valid), 32'(1));
      chk("bp_hold_src", 32'(out_src), 32'(0));
      chk("bp_hold_row", 32'(out_row), 32'(8'h05));
      chk("bp_hold_ready", 32'(req_ready), 32'(0));
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'(4'b0100));
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("bp_seq_valid", 32'(out_valid), 32'(1));
      chk("bp_seq_src", 32'(out_src), 32'(k % N));
    end
    req_valid = '0;
    repeat (3) tick();
    chk("bp_drained", 32'(out_valid), 32'(0));

    // Saturation, clear priority, and asynchronous reset mid-stream.
    req_word[11:0] = 12'h024;
    req_valid = 4'b0001;
    repeat (300) tick();
    chk("sat_corr_cnt", 32'(corr_cnt), 32'(8'hFF));
    tick();
    chk("sat_hold", 32'(corr_cnt), 32'(8'hFF));
    chk("clr_counted_now", 32'({out_valid, out_corr}), 32'(2'b11));
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_priority", 32'(corr_cnt), 32'(0));
    tick();
    chk("clr_then_count", 32'(corr_cnt), 32'(1));
    chk("clr_uncorr", 32'(uncorr_cnt), 32'(0));
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'(0));
    chk("arst_ready", 32'(req_ready), 32'(0));
    chk("arst_cnt", 32'(corr_cnt), 32'(0));
    tick();
    rst_n = 1'b1;
    req_valid = '0;
    repeat (3) tick();
    chk("post_rst_idle", 32'(out_valid), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
